// File: rtl/countdown_run_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : countdown_run_ctrl
// Brief    : HH:MM countdown run controller: set/run/pause/alarm sequencing
//            with BCD digit editing and per-tick borrow-chain decrement.
// Revision : 1.0 - initial release
// ============================================================================
module countdown_run_ctrl #(
    parameter int TICK_DIV    = 100000000,
    parameter int ALARM_TICKS = 10
) (
    input  logic       clk0,
    input  logic       rst_n,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_start,
    output logic [1:0] hour_t,
    output logic [3:0] hour_u,
    output logic [2:0] min_t,
    output logic [3:0] min_u,
    output logic [2:0] state,
    output logic [1:0] sel,
    output logic       tick_o,
    output logic       alarm
);

    localparam int c_CNT_W  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int c_ACNT_W = (ALARM_TICKS > 1) ? $clog2(ALARM_TICKS) : 1;
    localparam logic [c_CNT_W-1:0]  c_TICK_LAST  = c_CNT_W'(TICK_DIV - 1);
    localparam logic [c_ACNT_W-1:0] c_ALARM_LAST = c_ACNT_W'(ALARM_TICKS - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SET   = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_ALARM = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          ht_q, ht_d;
    logic [3:0]          hu_q, hu_d;
    logic [2:0]          mt_q, mt_d;
    logic [3:0]          mu_q, mu_d;
    logic [1:0]          sel_q, sel_d;
    logic [c_CNT_W-1:0]  cnt_q, cnt_d;
    logic [c_ACNT_W-1:0] acnt_q, acnt_d;
    logic                tick_q, tick_d;
    logic                alarm_q;

    logic w_tick;
    logic w_zero;
    logic w_one;

    assign w_tick = ((state_q == ST_RUN) || (state_q == ST_ALARM)) && (cnt_q == c_TICK_LAST);
    assign w_zero = (ht_q == 2'd0) && (hu_q == 4'd0) && (mt_q == 3'd0) && (mu_q == 4'd0);
    assign w_one  = (ht_q == 2'd0) && (hu_q == 4'd0) && (mt_q == 3'd0) && (mu_q == 4'd1);

    always_comb begin
        state_d = state_q;
        ht_d    = ht_q;
        hu_d    = hu_q;
        mt_d    = mt_q;
        mu_d    = mu_q;
        sel_d   = sel_q;
        cnt_d   = '0;
        acnt_d  = acnt_q;
        tick_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                sel_d = 2'd0;
                if (btn_start) begin
                    if (!w_zero) state_d = ST_RUN;
                end else if (btn_mode) begin
                    state_d = ST_SET;
                end
            end

            ST_SET: begin
                if (btn_start) begin
                    state_d = w_zero ? ST_IDLE : ST_RUN;
                    sel_d   = 2'd0;
                end else if (btn_mode) begin
                    if (sel_q == 2'd3) begin
                        state_d = ST_IDLE;
                        sel_d   = 2'd0;
                    end else begin
                        sel_d = sel_q + 2'd1;
                    end
                end else if (btn_inc) begin
                    case (sel_q)
                        2'd0: begin
                            ht_d = (ht_q >= 2'd2) ? 2'd0 : ht_q + 2'd1;
                            // Entering the 20s must keep the hour legal (<= 23).
                            if ((ht_q == 2'd1) && (hu_q > 4'd3)) hu_d = 4'd3;
                        end
                        2'd1: hu_d = (((ht_q == 2'd2) && (hu_q >= 4'd3)) || (hu_q >= 4'd9))
                                     ? 4'd0 : hu_q + 4'd1;
                        2'd2: mt_d = (mt_q >= 3'd5) ? 3'd0 : mt_q + 3'd1;
                        default: mu_d = (mu_q >= 4'd9) ? 4'd0 : mu_q + 4'd1;
                    endcase
                end
            end

            ST_RUN: begin
                cnt_d = w_tick ? '0 : cnt_q + c_CNT_W'(1);
                if (btn_start) begin
                    state_d = ST_PAUSE;
                end else if (w_tick && !w_zero) begin
                    tick_d = 1'b1;
                    if (mu_q != 4'd0) begin
                        mu_d = mu_q - 4'd1;
                    end else begin
                        mu_d = 4'd9;
                        if (mt_q != 3'd0) begin
                            mt_d = mt_q - 3'd1;
                        end else begin
                            mt_d = 3'd5;
                            if (hu_q != 4'd0) begin
                                hu_d = hu_q - 4'd1;
                            end else begin
                                hu_d = 4'd9;
                                ht_d = ht_q - 2'd1;
                            end
                        end
                    end
                    if (w_one) begin
                        state_d = ST_ALARM;
                        acnt_d  = '0;
                    end
                end
            end

            ST_PAUSE: begin
                cnt_d = cnt_q;
                if (btn_start) begin
                    state_d = ST_RUN;
                end else if (btn_mode) begin
                    state_d = ST_IDLE;
                end
            end

            ST_ALARM: begin
                cnt_d = w_tick ? '0 : cnt_q + c_CNT_W'(1);
                if (btn_start || btn_mode || btn_inc) begin
                    state_d = ST_IDLE;
                end else if (w_tick) begin
                    if (acnt_q == c_ALARM_LAST) state_d = ST_IDLE;
                    else                        acnt_d  = acnt_q + c_ACNT_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                sel_d   = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk0) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ht_q    <= 2'd0;
            hu_q    <= 4'd0;
            mt_q    <= 3'd0;
            mu_q    <= 4'd0;
            sel_q   <= 2'd0;
            cnt_q   <= '0;
            acnt_q  <= '0;
            tick_q  <= 1'b0;
            alarm_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ht_q    <= ht_d;
            hu_q    <= hu_d;
            mt_q    <= mt_d;
            mu_q    <= mu_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            acnt_q  <= acnt_d;
            tick_q  <= tick_d;
            alarm_q <= (state_d == ST_ALARM);
        end
    end

    assign hour_t = ht_q;
    assign hour_u = hu_q;
    assign min_t  = mt_q;
    assign min_u  = mu_q;
    assign state  = state_q;
    assign sel    = sel_q;
    assign tick_o = tick_q;
    assign alarm  = alarm_q;

endmodule
`default_nettype wire

// File: tb/tb_countdown_run_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_countdown_run_ctrl
// Brief    : Scoreboard bench for countdown_run_ctrl against a minute-count model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_countdown_run_ctrl;

    localparam int TICK_DIV    = 4;
    localparam int ALARM_TICKS = 2;

    localparam int M_IDLE  = 0;
    localparam int M_SET   = 1;
    localparam int M_RUN   = 2;
    localparam int M_PAUSE = 3;
    localparam int M_ALARM = 4;

    logic       clk0 = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic       btn_start = 1'b0;
    logic [1:0] hour_t;
    logic [3:0] hour_u;
    logic [2:0] min_t;
    logic [3:0] min_u;
    logic [2:0] state;
    logic [1:0] sel;
    logic       tick_o;
    logic       alarm;

    countdown_run_ctrl #(
        .TICK_DIV    (TICK_DIV),
        .ALARM_TICKS (ALARM_TICKS)
    ) dut (
        .clk0      (clk0),
        .rst_n     (rst_n),
        .btn_mode  (btn_mode),
        .btn_inc   (btn_inc),
        .btn_start (btn_start),
        .hour_t    (hour_t),
        .hour_u    (hour_u),
        .min_t     (min_t),
        .min_u     (min_u),
        .state     (state),
        .sel       (sel),
        .tick_o    (tick_o),
        .alarm     (alarm)
    );

    always #5 clk0 = ~clk0;

    typedef struct packed {
        logic [2:0] st;
        logic [1:0] ht;
        logic [3:0] hu;
        logic [2:0] mt;
        logic [3:0] mu;
        logic [1:0] sl;
        logic       tk;
        logic       al;
    } obs_t;

    typedef struct {
        obs_t  o;
        string tag;
    } item_t;

    item_t exp_q[$];
    int    errors = 0;
    int    checks = 0;
    string phase = "reset";

    // Reference model: time kept as digits for editing, as total minutes for counting.
    int m_state, m_ht, m_hu, m_mt, m_mu, m_sel, m_cnt, m_acnt;
    bit m_tick, m_alarm;

    function automatic int total_min();
        return (m_ht * 10 + m_hu) * 60 + m_mt * 10 + m_mu;
    endfunction

    task automatic set_total(input int t);
        m_ht = (t / 60) / 10;
        m_hu = (t / 60) % 10;
        m_mt = (t % 60) / 10;
        m_mu = (t % 60) % 10;
    endtask

    task automatic model_step(input bit rn, input bit bs, input bit bm, input bit bi);
        int  tot;
        bit  tk;
        int  nxt_cnt;
        if (!rn) begin
            m_state = M_IDLE; m_ht = 0; m_hu = 0; m_mt = 0; m_mu = 0;
            m_sel = 0; m_cnt = 0; m_acnt = 0; m_tick = 0; m_alarm = 0;
            return;
        end
        tot = total_min();
        tk  = (m_state == M_RUN || m_state == M_ALARM) && (m_cnt == TICK_DIV - 1);
        if (m_state == M_RUN || m_state == M_ALARM) nxt_cnt = (m_cnt + 1) % TICK_DIV;
        else if (m_state == M_PAUSE)                nxt_cnt = m_cnt;
        else                                        nxt_cnt = 0;
        m_tick = 0;
        case (m_state)
            M_IDLE: begin
                if (bs) begin
                    if (tot != 0) m_state = M_RUN;
                end else if (bm) begin
                    m_state = M_SET; m_sel = 0;
                end
            end
            M_SET: begin
                if (bs) begin
                    m_state = (tot != 0) ? M_RUN : M_IDLE; m_sel = 0;
                end else if (bm) begin
                    if (m_sel == 3) begin m_state = M_IDLE; m_sel = 0; end
                    else m_sel++;
                end else if (bi) begin
                    case (m_sel)
                        0: begin
                            m_ht = (m_ht + 1) % 3;
                            if (m_ht == 2 && m_hu > 3) m_hu = 3;
                        end
                        1: m_hu = (m_ht == 2) ? (m_hu + 1) % 4 : (m_hu + 1) % 10;
                        2: m_mt = (m_mt + 1) % 6;
                        default: m_mu = (m_mu + 1) % 10;
                    endcase
                end
            end
            M_RUN: begin
                if (bs) m_state = M_PAUSE;
                else if (tk && tot != 0) begin
                    set_total(tot - 1);
                    m_tick = 1;
                    if (tot - 1 == 0) begin m_state = M_ALARM; m_acnt = 0; end
                end
            end
            M_PAUSE: begin
                if (bs)      m_state = M_RUN;
                else if (bm) m_state = M_IDLE;
            end
            default: begin
                if (bs || bm || bi) m_state = M_IDLE;
                else if (tk) begin
                    m_acnt++;
                    if (m_acnt == ALARM_TICKS) m_state = M_IDLE;
                end
            end
        endcase
        m_cnt   = nxt_cnt;
        m_alarm = (m_state == M_ALARM);
    endtask

    function automatic obs_t model_obs();
        obs_t o;
        o.st = 3'(m_state); o.ht = 2'(m_ht); o.hu = 4'(m_hu); o.mt = 3'(m_mt);
        o.mu = 4'(m_mu);    o.sl = 2'(m_sel); o.tk = m_tick;   o.al = m_alarm;
        return o;
    endfunction

    // One clock of stimulus: drive after negedge, predict, queue the expectation.
    task automatic cyc(input bit rn, input bit bs, input bit bm, input bit bi);
        item_t it;
        @(negedge clk0);
        rst_n = rn; btn_start = bs; btn_mode = bm; btn_inc = bi;
        model_step(rn, bs, bm, bi);
        it.o   = model_obs();
        it.tag = phase;
        exp_q.push_back(it);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset(input int n);
        repeat (n) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic incs(input int n);
        repeat (n) cyc(1'b1, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic mode();
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic start();
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic preset(input int a, input int b, input int c, input int d);
        mode(); incs(a);
        mode(); incs(b);
        mode(); incs(c);
        mode(); incs(d);
        mode();
    endtask

    initial begin : monitor
        item_t it;
        obs_t  act;
        forever begin
            @(posedge clk0);
            #1;
            if (exp_q.size() > 0) begin
                it  = exp_q.pop_front();
                act = {state, hour_t, hour_u, min_t, min_u, sel, tick_o, alarm};
                checks++;
                if (act !== it.o) begin
                    errors++;
                    $display("FAIL %s t=%0t actual st=%0d %0d%0d:%0d%0d sel=%0d tick=%0b alarm=%0b required st=%0d %0d%0d:%0d%0d sel=%0d tick=%0b alarm=%0b",
                             it.tag, $time, act.st, act.ht, act.hu, act.mt, act.mu, act.sl, act.tk, act.al,
                             it.o.st, it.o.ht, it.o.hu, it.o.mt, it.o.mu, it.o.sl, it.o.tk, it.o.al);
                end
            end
        end
    end

    initial begin : stimulus
        int r;
        phase = "reset";
        do_reset(2);
        idle(2);

        phase = "set_clamp";
        mode(); incs(2); mode(); incs(5); mode(); mode(); mode();
        idle(2);
        mode(); incs(3); idle(1);
        mode(); mode(); mode(); mode();

        phase = "run_borrow";
        do_reset(1);
        preset(0, 1, 0, 0);
        start();
        idle(30);

        phase = "alarm_timeout";
        do_reset(1);
        preset(0, 0, 0, 1);
        start();
        idle(20);

        phase = "alarm_ack";
        preset(0, 0, 0, 1);
        start();
        idle(6);
        incs(1);
        idle(3);

        phase = "pause_resume";
        do_reset(1);
        preset(0, 0, 3, 0);
        start();
        idle(6);
        start();
        idle(20);
        start();
        idle(9);
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        idle(3);
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        idle(5);
        mode(); incs(1);
        idle(2);
        start();
        mode();
        idle(2);

        phase = "zero_start_reset";
        do_reset(1);
        start();
        idle(2);
        preset(0, 0, 0, 5);
        start();
        idle(7);
        do_reset(1);
        idle(3);

        phase = "random";
        for (int ep = 0; ep < 40; ep++) begin
            do_reset(1);
            preset($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 2),
                   $urandom_range(0, 9));
            start();
            for (int k = 0; k < int'($urandom_range(40, 250)); k++) begin
                r = $urandom_range(0, 39);
                if ($urandom_range(0, 499) == 0) cyc(1'b0, 1'b0, 1'b0, 1'b0);
                else cyc(1'b1, r == 0 || r == 3, r == 1 || r == 3, r == 2 || r == 3);
            end
        end

        phase = "drain";
        repeat (3) @(negedge clk0);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain actual pending=%0d required pending=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
